// File: rtl/speck_decrypt_core.sv
// Iterative Speck64/128 decryption core: 27-cycle key expansion into a round-key store, then 27 inverse rounds.
// Optional macro SPECK_DEC_KEY_CACHE_EN skips expansion when the key matches the last expanded key.
module speck_decrypt_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [4*W-1:0] key_in,
    input  logic [2*W-1:0] ct_in,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] pt_out
);

    localparam int ROUNDS = 27;
    localparam int ALPHA  = 8;
    localparam int BETA   = 3;
    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [2*W-1:0] pt_q, pt_d;
    logic           hit;

    logic [W-1:0] x_q, y_q, k_q, l0_q, l1_q, l2_q;
    logic [W-1:0] rk_q [0:ROUNDS-1];
    logic [W-1:0] l_new, k_next, rk_sel, x_dec, y_dec;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int s);
        return (v >> s) | (v << (W - s));
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int s);
        return (v << s) | (v >> (W - s));
    endfunction

    // l0_q..l2_q hold l[i], l[i+1], l[i+2] while k_q holds k[i] for the current idx
    assign l_new  = (k_q + rotr(l0_q, ALPHA)) ^ W'(idx_q);
    assign k_next = rotl(k_q, BETA) ^ l_new;
    assign rk_sel = rk_q[idx_q];
    assign y_dec  = rotr(x_q ^ y_q, BETA);
    assign x_dec  = rotl((x_q ^ rk_sel) - y_dec, ALPHA);

`ifdef SPECK_DEC_KEY_CACHE_EN
    logic [4*W-1:0] ckey_q;
    logic           cvalid_q, cvalid_d;

    assign hit = cvalid_q && (key_in == ckey_q);

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start && !hit) ckey_q <= key_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cvalid_q <= 1'b0;
        else        cvalid_q <= cvalid_d;
    end

    always_comb begin
        cvalid_d = cvalid_q;
        if (state_q == IDLE && start && !hit)          cvalid_d = 1'b0;
        else if (state_q == EXPAND && idx_q == LAST_IDX) cvalid_d = 1'b1;
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pt_d    = pt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = hit ? DECRYPT : EXPAND;
                    idx_d   = hit ? LAST_IDX : 5'd0;
                end
            end
            EXPAND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DECRYPT;
                    idx_d   = LAST_IDX;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DECRYPT: begin
                if (idx_q == 5'd0) begin
                    state_d = DONE;
                    pt_d    = {x_dec, y_dec};
                end else begin
                    idx_d = idx_q - 5'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and round-key store carry no reset; they are always reloaded before use
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            x_q  <= ct_in[2*W-1:W];
            y_q  <= ct_in[W-1:0];
            k_q  <= key_in[W-1:0];
            l0_q <= key_in[2*W-1:W];
            l1_q <= key_in[3*W-1:2*W];
            l2_q <= key_in[4*W-1:3*W];
        end else if (state_q == EXPAND) begin
            rk_q[idx_q] <= k_q;
            k_q         <= k_next;
            l0_q        <= l1_q;
            l1_q        <= l2_q;
            l2_q        <= l_new;
        end else if (state_q == DECRYPT) begin
            x_q <= x_dec;
            y_q <= y_dec;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign pt_out = pt_q;

endmodule

// File: tb/tb_speck_decrypt_core.sv
// Randomized bench for speck_decrypt_core against a plain-arithmetic Speck64/128 model and a cycle-level timing model.
module tb_speck_decrypt_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [63:0]  ct_in = '0;
    logic         busy, done;
    logic [63:0]  pt_out;

    int n_checks = 0;
    int n_errors = 0;
    int ops_done = 0;
    int done_seen = 0;

`ifdef SPECK_DEC_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    speck_decrypt_core #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .ct_in(ct_in), .busy(busy), .done(done), .pt_out(pt_out)
    );

    always #5 clk = ~clk;

    typedef logic [26:0][31:0] ks_t;

    function automatic logic [31:0] rotr(input logic [31:0] v, input int s);
        return (v >> s) | (v << (32 - s));
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic ks_t schedule(input logic [127:0] key);
        logic [31:0] l [0:29];
        ks_t k;
        k[0] = key[31:0];
        l[0] = key[63:32];
        l[1] = key[95:64];
        l[2] = key[127:96];
        for (int i = 0; i < 26; i++) begin
            l[i+3]  = (k[i] + rotr(l[i], 8)) ^ 32'(i);
            k[i+1]  = rotl(k[i], 3) ^ l[i+3];
        end
        return k;
    endfunction

    function automatic logic [63:0] encrypt(input logic [127:0] key, input logic [63:0] pt);
        ks_t k = schedule(key);
        logic [31:0] x = pt[63:32], y = pt[31:0];
        for (int i = 0; i < 27; i++) begin
            x = (rotr(x, 8) + y) ^ k[i];
            y = rotl(y, 3) ^ x;
        end
        return {x, y};
    endfunction

    function automatic logic [63:0] decrypt(input logic [127:0] key, input logic [63:0] ct);
        ks_t k = schedule(key);
        logic [31:0] x = ct[63:32], y = ct[31:0];
        for (int i = 26; i >= 0; i--) begin
            y = rotr(x ^ y, 3);
            x = rotl((x ^ k[i]) - y, 8);
        end
        return {x, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timing model: an accepted request finishes after a fixed number of edges, then one done cycle
    logic         m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0;
    logic [63:0]  m_pt = '0, m_pending = '0;
    logic [127:0] m_key = '0;
    int           m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_pt = '0; m_rem = 0;
        end else if (m_done) begin
            m_done = 1'b0; m_busy = 1'b0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1; m_pt = m_pending; m_valid = 1'b1;
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_pending = decrypt(key_in, ct_in);
            if (CACHE && m_valid && key_in == m_key) m_rem = 27;
            else begin
                m_rem = 54; m_valid = 1'b0; m_key = key_in;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("pt_out", pt_out, m_pt);
        if (done) done_seen++;
    end

    function automatic int exp_latency(input logic [127:0] key);
        return (CACHE && m_valid && key == m_key) ? 27 : 54;
    endfunction

    task automatic do_op(input logic [127:0] key, input logic [63:0] ct, input int exp_lat,
                         input bit noise, output logic [63:0] pt);
        int lat = 0;
        @(posedge clk); #1;
        start = 1'b1; key_in = key; ct_in = ct;
        @(posedge clk); #1;
        start = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (done || lat >= 200) break;
            if (noise && (lat == 5 || lat == 30)) begin
                start = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
                ct_in = {$urandom, $urandom};
            end
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        pt = pt_out;
        if (done) ops_done++;
    endtask

    localparam logic [127:0] TV_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  TV_CT  = 64'h8c6fa548_454e028b;
    localparam logic [63:0]  TV_PT  = 64'h3b726574_7475432d;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  pt;
        logic [127:0] key, last_key;
        logic [63:0]  ct;

        check("model_encrypt_tv", encrypt(TV_KEY, TV_PT), TV_CT);
        check("model_decrypt_tv", decrypt(TV_KEY, TV_CT), TV_PT);

        repeat (3) @(posedge clk);
        #1 check("reset_busy", 64'(busy), 64'd0);
        check("reset_pt", pt_out, 64'd0);
        #2 rst_n = 1'b1;

        do_op(TV_KEY, TV_CT, 54, 1'b0, pt);
        check("tv_pt", pt, TV_PT);

        do_op(TV_KEY, TV_CT, exp_latency(TV_KEY), 1'b1, pt);
        check("noise_pt", pt, TV_PT);

        do_op(TV_KEY, TV_CT, CACHE ? 27 : 54, 1'b0, pt);
        check("b2b_pt", pt, TV_PT);

        // Reset asserted while the DECRYPT round index is 10
        @(posedge clk); #1;
        start = 1'b1; key_in = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210; ct_in = TV_CT;
        @(posedge clk); #1 start = 1'b0;
        repeat (43) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pt", pt_out, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        do_op(TV_KEY, TV_CT, 54, 1'b0, pt);
        check("after_rst_pt", pt, TV_PT);

        do_op({128{1'b1}}, 64'd0, 54, 1'b0, pt);
        check("ones_pt", pt, decrypt({128{1'b1}}, 64'd0));
        check("ones_roundtrip", encrypt({128{1'b1}}, pt), 64'd0);

        last_key = {128{1'b1}};
        for (int n = 0; n < 1000; n++) begin
            key = ($urandom_range(0, 9) < 3) ? last_key : {$urandom, $urandom, $urandom, $urandom};
            ct = {$urandom, $urandom};
            do_op(key, ct, exp_latency(key), 1'b0, pt);
            check("rand_roundtrip", encrypt(key, pt), ct);
            last_key = key;
        end

        repeat (3) @(posedge clk);
        #1 check("done_count", 64'(done_seen), 64'(ops_done));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
